// File: rtl/numled_arbiter.sv
// Purpose: arbitrates CPU and debug writes to a multiplexed 8-digit display and commits values only at frame boundaries.
// Latency: an accepted value reaches num_out in the cycle after the next frame_end, or one cycle later if the display is off.
// Backpressure: one value in flight; both readies drop while a value is pending, and priority alternates after each accept.
module numled_arbiter #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_data,
  output logic        cpu_ready,
  input  logic        dbg_valid,
  input  logic [31:0] dbg_data,
  output logic        dbg_ready,
  input  logic        disp_on,
  output logic        light,
  output logic [31:0] num_out,
  output logic        owner,
  output logic [2:0]  digit_sel,
  output logic        scan_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Priority encoding: 0 favours the CPU, 1 favours the debug monitor.
  localparam logic PRIO_CPU = 1'b0;
  localparam logic PRIO_DBG = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          prio;
  logic [31:0]   pend_dat;
  logic          pend_src;
  logic          frame_end;
  logic          cpu_hs;
  logic          dbg_hs;
  logic          commit;

  // Tick is decoded from the prescaler so it lands in the same cycle the count hits its last value.
  assign scan_tick = !rst && disp_on && (cnt == CNT_LAST);
  assign frame_end = scan_tick && (digit_sel == 3'd7);

  // Prescaler and digit counter; both parked at zero while the display is off so scanning restarts at digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit_sel <= 3'd0;
    end else if (!disp_on) begin
      cnt       <= '0;
      digit_sel <= 3'd0;
    end else if (scan_tick) begin
      cnt       <= '0;
      digit_sel <= digit_sel + 3'd1;
    end else begin
      cnt       <= cnt + CNT_ONE;
    end
  end

  // Driver enable follows disp_on one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      light <= 1'b0;
    end else begin
      light <= disp_on;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, readies and handshake/commit strobes; readies depend only on state, priority and valids.
  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    dbg_ready = 1'b0;
    cpu_hs    = 1'b0;
    dbg_hs    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          cpu_ready = !dbg_valid || (prio == PRIO_CPU);
          dbg_ready = !cpu_valid || (prio == PRIO_DBG);
        end
        cpu_hs = cpu_valid && cpu_ready;
        dbg_hs = dbg_valid && dbg_ready && !cpu_hs;
        if (cpu_hs || dbg_hs) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        // With the display dark there is no frame to tear, so commit straight away.
        commit = !rst && (frame_end || !disp_on);
        if (commit) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pending register, round-robin priority and the committed display value.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= PRIO_CPU;
      pend_dat <= 32'h0;
      pend_src <= 1'b0;
      num_out  <= 32'h0;
      owner    <= 1'b0;
    end else begin
      if (cpu_hs) begin
        pend_dat <= cpu_data;
        pend_src <= 1'b0;
        prio     <= PRIO_DBG;
      end else if (dbg_hs) begin
        pend_dat <= dbg_data;
        pend_src <= 1'b1;
        prio     <= PRIO_CPU;
      end
      if (commit) begin
        num_out <= pend_dat;
        owner   <= pend_src;
      end
    end
  end

endmodule

// File: doc/numled_arbiter.md
NUMLED_ARBITER -- requirements
Module: numled_arbiter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000; system clocks per digit-scan tick; legal values ≥ 2.
REQ-002 SHALL have port clk, input, 1 bit; the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port cpu_valid, input, 1 bit; CPU MMIO write request.
REQ-005 SHALL have port cpu_data, input, 32 bits; CPU display value, eight hex nibbles, nibble 0 = rightmost digit.
REQ-006 SHALL have port cpu_ready, output, 1 bit; CPU request accepted this cycle when cpu_valid is also high.
REQ-007 SHALL have port dbg_valid, input, 1 bit; debug-monitor write request.
REQ-008 SHALL have port dbg_data, input, 32 bits; debug display value.
REQ-009 SHALL have port dbg_ready, output, 1 bit; debug request accepted this cycle when dbg_valid is also high.
REQ-010 SHALL have port disp_on, input, 1 bit; display enable level.
REQ-011 SHALL have port light, output, 1 bit; enable to the 7-segment scan driver.
REQ-012 SHALL have port num_out, output, 32 bits; committed display value to the driver.
REQ-013 SHALL have port owner, output, 1 bit; source of num_out: 0 = CPU, 1 = debug.
REQ-014 SHALL have port digit_sel, output, 3 bits; currently scanned digit index.
REQ-015 SHALL have port scan_tick, output, 1 bit; one-cycle pulse at each digit advance.

Function
REQ-016 SHALL keep a prescaler counting 0..SCAN_DIV-1 while disp_on=1; scan_tick=1 exactly in the cycle the count equals SCAN_DIV-1, and the count then wraps to 0.
REQ-017 SHALL increment digit_sel on each scan_tick, modulo 8 (7 -> 0).
REQ-018 SHALL define frame_end as scan_tick=1 with digit_sel=7.
REQ-019 SHALL, while disp_on=0, hold the prescaler and digit_sel at 0 and drive scan_tick=0; on disp_on rising, scanning restarts from digit 0 with prescaler 0.
REQ-020 SHALL drive light as disp_on registered by one cycle.
REQ-021 SHALL implement FSM states IDLE and PENDING.
REQ-022 SHALL, in IDLE, assert cpu_ready = !dbg_valid or priority=CPU, and dbg_ready = !cpu_valid or priority=DBG; at most one handshake per cycle.
REQ-023 SHALL, in PENDING, drive cpu_ready=0 and dbg_ready=0.
REQ-024 SHALL, on a handshake in IDLE, latch data and source into a pending register, set priority to the other requester, and enter PENDING next cycle.
REQ-025 SHALL leave priority unchanged when only one requester is valid and its handshake does not complete.
REQ-026 SHALL, in PENDING, commit the pending value to num_out and owner on the cycle after frame_end, then return to IDLE.
REQ-027 SHALL, in PENDING with disp_on=0, commit on the next cycle without waiting for frame_end.
REQ-028 SHALL never change num_out except by a commit; no tearing within a scan frame.
REQ-029 SHALL ignore request data when valid is low; ready is combinational from state, priority, and valids only, never from data.
REQ-030 SHALL, when frame_end and a new handshake would coincide, have no conflict: handshakes occur only in IDLE, and commits occur only from PENDING.

Reset
REQ-031 SHALL, with rst=1 at a clock edge, set state=IDLE, priority=CPU, prescaler=0, digit_sel=0, scan_tick=0, light=0, num_out=32'h0, owner=0, and pending register=0.
REQ-032 SHALL, on rst mid-PENDING, discard the pending value; num_out returns to 0.
REQ-033 SHALL hold cpu_ready=0 and dbg_ready=0 during the reset cycle.

Verification (SCAN_DIV=4, frame = 32 cycles)
REQ-034 SHALL cover: reset; disp_on=1; CPU writes 32'h12345678 -> cpu_ready=1; num_out stays 0 until the cycle after the first frame_end, then becomes 32'h12345678 with owner=0.
REQ-035 SHALL cover: both valid from IDLE after reset -> CPU accepted first; after its commit, dbg accepted; priority then returns to CPU.
REQ-036 SHALL cover: scan counting -> scan_tick every 4th cycle; digit_sel sequence 0..7,0; frame_end at digit 7.
REQ-037 SHALL cover: disp_on=0 while PENDING with 32'hDEADBEEF -> commit next cycle; light=0 one cycle after disp_on falls; digit_sel=0.
REQ-038 SHALL cover: rst pulse while PENDING with 32'hCAFEF00D -> num_out=0, owner=0, state IDLE, value never committed.
REQ-039 SHALL cover: second CPU request during PENDING -> cpu_ready=0 until the commit; accepted in the first IDLE cycle.
